minhash_sig_tracker: RTL and testbench
======================================

# minhash_sig_tracker

Downstream stage of the per-seed MurmurHash3 units in the LSH MinHash accelerator. It consumes finalized 32-bit hash values tagged with the index of the hash function (seed) that produced them and keeps a running minimum per index across all shingles of a document. At document end it streams the resulting MinHash signature, one 32-bit word per hash function, to the banding/LSH stage over a valid/ready handshake.

## Interface
- NUM_HASH, 4, number of hash functions (signature length); ≥2.
- IDX_W, $clog2(NUM_HASH), width of hash/signature index.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin new document (pulse).
- hash_valid  in  1  hash_val/hash_idx valid this cycle (driven from murmur flag).
- hash_idx  in  IDX_W  hash-function index of hash_val.
- hash_val  in  32  finalized hash value.
- doc_end  in  1  last shingle of document delivered (pulse).
- busy  out  1  block is in ACCUM or DRAIN.
- sig_valid  out  1  sig_val/sig_idx valid.
- sig_ready  in  1  downstream accepts current signature word.
- sig_idx  out  IDX_W  index of current signature word.
- sig_val  out  32  minimum hash for sig_idx.
- done  out  1  one-cycle pulse after last signature word accepted.
- hash_cnt  out  16  number of hashes accepted this document, saturates at 0xFFFF.
- drop_err  out  1  sticky: hash_valid seen outside ACCUM or hash_idx ≥ NUM_HASH; cleared by start or reset.

## Operation
- Storage: NUM_HASH × 32-bit min registers, 16-bit hash_cnt, IDX_W drain pointer.
- States: IDLE, ACCUM, DRAIN.
- IDLE: on start → all mins = 0xFFFFFFFF, hash_cnt = 0, drop_err = 0, → ACCUM. doc_end ignored.
- ACCUM: on hash_valid with hash_idx < NUM_HASH: min[hash_idx] ← hash_val if hash_val < min[hash_idx] (unsigned, strict; equal → no change); hash_cnt += 1 saturating.
- ACCUM, doc_end: → DRAIN, pointer = 0. A hash_valid in the same cycle as doc_end is applied first and is part of the signature.
- ACCUM, start: re-initialise as from IDLE (document restart); a simultaneous hash_valid is discarded, not counted, no drop_err.
- DRAIN: sig_valid = 1, sig_idx = pointer, sig_val = min[pointer]. On sig_valid && sig_ready: pointer += 1; after index NUM_HASH-1 accepted → IDLE, done pulses next cycle. sig_val/sig_idx stable while sig_ready low.
- DRAIN: start and doc_end ignored; hash_valid sets drop_err, no min/count change.
- Invalid hash_idx (≥ NUM_HASH, non-power-of-two NUM_HASH only) in ACCUM: dropped, drop_err set, not counted.
- Empty document (start then doc_end, no hashes): signature words all 0xFFFFFFFF, hash_cnt = 0.
- min registers and hash_cnt hold their values after DRAIN until next start.

## Timing
- Reset: state IDLE, busy 0, sig_valid 0, sig_idx 0, sig_val 0, done 0, hash_cnt 0, drop_err 0, mins 0xFFFFFFFF.
- hash update registered: min visible one cycle after hash_valid; back-to-back hashes to same index every cycle supported (comparison uses updated value).
- doc_end sampled at edge N → sig_valid high from cycle N+1.
- sig_ready held high: NUM_HASH words on consecutive cycles N+1..N+NUM_HASH; done high in cycle N+NUM_HASH+1, busy low same cycle.
- busy high from cycle after start through last accepted word.
- sig_val outputs 0 when sig_valid low.
- reset mid-DRAIN: next cycle all outputs at reset values, no done pulse.

## Test plan
- Basic: NUM_HASH=4, start; hashes (idx,val) (0,0x80000000),(1,0x10),(0,0x7FFFFFFF),(2,0x5),(2,0x9); doc_end; sig_ready=1 → words 0x7FFFFFFF,0x10,0x5,0xFFFFFFFF idx 0..3 on consecutive cycles, hash_cnt=5, done one pulse 5 cycles after doc_end.
- Backpressure: same doc, sig_ready low 3 cycles then toggling 1/0 → each word held stable, order 0..3, no word lost or duplicated, done after 4th handshake.
- Simultaneous: hash (3,0x1) in same cycle as doc_end → word 3 = 0x1, hash_cnt includes it; start with same-cycle hash in ACCUM → hash discarded, hash_cnt=0.
- Empty doc and equal values: start, doc_end → four 0xFFFFFFFF words; separate doc with (1,0x20) twice → word 1 = 0x20, hash_cnt=2.
- Errors: hash_valid in IDLE and DRAIN → drop_err=1, signature unchanged; next start clears drop_err to 0.
- Reset mid-op: assert reset during DRAIN after 2 accepted words → sig_valid 0, busy 0, no done; new document afterward produces correct signature from fresh 0xFFFFFFFF state.

Source files
------------

// File: rtl/minhash_sig_tracker.sv
// Per-seed running-minimum tracker for MinHash: accumulates the minimum hash per
// hash-function index over one document, then drains the signature over valid/ready.
module minhash_sig_tracker #(
    parameter int NUM_HASH = 4,
    parameter int IDX_W    = $clog2(NUM_HASH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hash_valid,
    input  logic [IDX_W-1:0] hash_idx,
    input  logic [31:0]      hash_val,
    input  logic             doc_end,
    output logic             busy,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [IDX_W-1:0] sig_idx,
    output logic [31:0]      sig_val,
    output logic             done,
    output logic [15:0]      hash_cnt,
    output logic             drop_err
);

    // Signature handshake: a word transfers on a cycle where sig_valid && sig_ready;
    // sig_idx/sig_val hold steady until that transfer happens.
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    localparam logic [IDX_W:0]   NUM_HASH_X = (IDX_W+1)'(NUM_HASH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_HASH - 1);

    state_t           state_q, state_d;
    logic [31:0]      min_q [NUM_HASH];
    logic [31:0]      min_d [NUM_HASH];
    logic [15:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             drop_q, drop_d;
    logic             done_q, done_d;
    logic             idx_ok;

    assign idx_ok = {1'b0, hash_idx} < NUM_HASH_X;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        drop_d  = drop_q;
        done_d  = 1'b0;
        for (int i = 0; i < NUM_HASH; i++) begin
            min_d[i] = min_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_HASH; i++) begin
                        min_d[i] = 32'hFFFF_FFFF;
                    end
                    cnt_d   = 16'd0;
                    drop_d  = 1'b0;
                    state_d = S_ACCUM;
                end else if (hash_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_ACCUM: begin
                if (start) begin
                    // Restart discards any hash arriving in the same cycle.
                    for (int i = 0; i < NUM_HASH; i++) begin
                        min_d[i] = 32'hFFFF_FFFF;
                    end
                    cnt_d  = 16'd0;
                    drop_d = 1'b0;
                end else begin
                    if (hash_valid) begin
                        if (idx_ok) begin
                            if (hash_val < min_q[hash_idx]) begin
                                min_d[hash_idx] = hash_val;
                            end
                            if (cnt_q != 16'hFFFF) begin
                                cnt_d = cnt_q + 16'd1;
                            end
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                    if (doc_end) begin
                        ptr_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (hash_valid) begin
                    drop_d = 1'b1;
                end
                if (sig_ready) begin
                    if (ptr_q == LAST_IDX) begin
                        ptr_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            ptr_q   <= '0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_HASH; i++) begin
                min_q[i] <= 32'hFFFF_FFFF;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_HASH; i++) begin
                min_q[i] <= min_d[i];
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign sig_valid = (state_q == S_DRAIN);
    assign sig_idx   = ptr_q;
    assign sig_val   = sig_valid ? min_q[ptr_q] : 32'd0;
    assign done      = done_q;
    assign hash_cnt  = cnt_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_minhash_sig_tracker.sv
// Directed-vector bench for minhash_sig_tracker with an expected-word queue for the drained signature.
module tb_minhash_sig_tracker;

    localparam int NUM_HASH = 4;
    localparam int IDX_W    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             hash_valid;
    logic [IDX_W-1:0] hash_idx;
    logic [31:0]      hash_val;
    logic             doc_end;
    logic             busy;
    logic             sig_valid;
    logic             sig_ready;
    logic [IDX_W-1:0] sig_idx;
    logic [31:0]      sig_val;
    logic             done;
    logic [15:0]      hash_cnt;
    logic             drop_err;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    minhash_sig_tracker #(.NUM_HASH(NUM_HASH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .hash_valid(hash_valid),
        .hash_idx(hash_idx), .hash_val(hash_val), .doc_end(doc_end), .busy(busy),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_idx(sig_idx),
        .sig_val(sig_val), .done(done), .hash_cnt(hash_cnt), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_hash(input logic [IDX_W-1:0] idx, input logic [31:0] val);
        hash_valid = 1'b1;
        hash_idx   = idx;
        hash_val   = val;
        tick();
        hash_valid = 1'b0;
    endtask

    task automatic pulse_doc_end();
        doc_end = 1'b1;
        tick();
        doc_end = 1'b0;
    endtask

    task automatic push_sig(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(w3);
    endtask

    // pattern 0: sig_ready held high; pattern 1: low 3 cycles then toggling 1/0.
    task automatic drain(input int pattern, input logic [15:0] exp_cnt);
        int n   = 0;
        int cyc = 0;
        logic [31:0] exp_w;
        while (n < NUM_HASH && cyc < 50) begin
            if (pattern == 0) sig_ready = 1'b1;
            else              sig_ready = (cyc >= 3) && (cyc % 2 == 1);
            @(negedge clk);
            check_eq("drain_valid", {31'd0, sig_valid}, 32'd1);
            check_eq("drain_busy", {31'd0, busy}, 32'd1);
            check_eq("drain_idx", {30'd0, sig_idx}, n);
            exp_w = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
            check_eq("drain_val", sig_val, exp_w);
            if (sig_ready) begin
                void'(exp_q.pop_front());
                n++;
            end
            tick();
            cyc++;
        end
        sig_ready = 1'b0;
        check_eq("drain_words", n, NUM_HASH);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("busy_after", {31'd0, busy}, 32'd0);
        check_eq("valid_after", {31'd0, sig_valid}, 32'd0);
        check_eq("val_zero_idle", sig_val, 32'd0);
        check_eq("cnt_hold", {16'd0, hash_cnt}, {16'd0, exp_cnt});
        tick();
        @(negedge clk);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hash_valid = 1'b0; hash_idx = '0;
        hash_val = '0; doc_end = 1'b0; sig_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_valid", {31'd0, sig_valid}, 32'd0);
        check_eq("rst_idx", {30'd0, sig_idx}, 32'd0);
        check_eq("rst_val", sig_val, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_cnt", {16'd0, hash_cnt}, 32'd0);
        check_eq("rst_drop", {31'd0, drop_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic document, ready held high
        pulse_start();
        @(negedge clk);
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        tick();
        send_hash(2'd0, 32'h8000_0000);
        send_hash(2'd1, 32'h0000_0010);
        send_hash(2'd0, 32'h7FFF_FFFF);
        send_hash(2'd2, 32'h0000_0005);
        send_hash(2'd2, 32'h0000_0009);
        pulse_doc_end();
        check_eq("basic_cnt", {16'd0, hash_cnt}, 32'd5);
        check_eq("basic_drop", {31'd0, drop_err}, 32'd0);
        push_sig(32'h7FFF_FFFF, 32'h10, 32'h5, 32'hFFFF_FFFF);
        drain(0, 16'd5);

        // Same document under backpressure
        pulse_start();
        send_hash(2'd0, 32'h8000_0000);
        send_hash(2'd1, 32'h0000_0010);
        send_hash(2'd0, 32'h7FFF_FFFF);
        send_hash(2'd2, 32'h0000_0005);
        send_hash(2'd2, 32'h0000_0009);
        pulse_doc_end();
        push_sig(32'h7FFF_FFFF, 32'h10, 32'h5, 32'hFFFF_FFFF);
        drain(1, 16'd5);

        // Hash in the same cycle as doc_end is part of the signature
        pulse_start();
        send_hash(2'd0, 32'h33);
        hash_valid = 1'b1; hash_idx = 2'd3; hash_val = 32'h1;
        pulse_doc_end();
        hash_valid = 1'b0;
        push_sig(32'h33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        drain(0, 16'd2);

        // Restart in ACCUM discards the same-cycle hash
        pulse_start();
        send_hash(2'd1, 32'h10);
        hash_valid = 1'b1; hash_idx = 2'd2; hash_val = 32'h2;
        pulse_start();
        hash_valid = 1'b0;
        @(negedge clk);
        check_eq("restart_cnt", {16'd0, hash_cnt}, 32'd0);
        check_eq("restart_drop", {31'd0, drop_err}, 32'd0);
        tick();
        pulse_doc_end();
        push_sig(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain(0, 16'd0);

        // Empty document
        pulse_start();
        pulse_doc_end();
        push_sig(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain(0, 16'd0);

        // Equal values keep the minimum; back-to-back same index uses updated value
        pulse_start();
        send_hash(2'd1, 32'h20);
        send_hash(2'd1, 32'h20);
        send_hash(2'd3, 32'h9);
        send_hash(2'd3, 32'h4);
        pulse_doc_end();
        push_sig(32'hFFFF_FFFF, 32'h20, 32'hFFFF_FFFF, 32'h4);
        drain(0, 16'd4);

        // hash_valid in IDLE sets drop_err; start clears it
        send_hash(2'd0, 32'h0);
        @(negedge clk);
        check_eq("idle_drop", {31'd0, drop_err}, 32'd1);
        check_eq("idle_cnt", {16'd0, hash_cnt}, 32'd4);
        tick();
        pulse_start();
        check_eq("start_clr_drop", {31'd0, drop_err}, 32'd0);
        send_hash(2'd0, 32'h5);
        pulse_doc_end();
        send_hash(2'd0, 32'h1);
        @(negedge clk);
        check_eq("drain_drop", {31'd0, drop_err}, 32'd1);
        tick();
        push_sig(32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain(0, 16'd1);
        pulse_start();
        check_eq("start_clr_drop2", {31'd0, drop_err}, 32'd0);
        pulse_doc_end();
        push_sig(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain(0, 16'd0);

        // Reset during DRAIN after two accepted words
        pulse_start();
        send_hash(2'd1, 32'h7);
        pulse_doc_end();
        sig_ready = 1'b1;
        @(negedge clk);
        check_eq("rmid_w0", sig_val, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        check_eq("rmid_w1", sig_val, 32'h7);
        tick();
        sig_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rmid_valid", {31'd0, sig_valid}, 32'd0);
        check_eq("rmid_busy", {31'd0, busy}, 32'd0);
        check_eq("rmid_done", {31'd0, done}, 32'd0);
        check_eq("rmid_val", sig_val, 32'd0);
        check_eq("rmid_idx", {30'd0, sig_idx}, 32'd0);
        check_eq("rmid_cnt", {16'd0, hash_cnt}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("rmid_no_done", {31'd0, done}, 32'd0);
        tick();
        exp_q.delete();
        pulse_start();
        send_hash(2'd3, 32'hA);
        pulse_doc_end();
        push_sig(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA);
        drain(0, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
